// File: rtl/matvec_engine.sv
// Embedding-row fetch or Q-format matrix-vector product over a single-outstanding
// read port; one result element is streamed out per output row.
module matvec_engine #(
    parameter int DATA_W    = 16,
    parameter int FRAC_BITS = 8,
    parameter int IN_DIM    = 16,
    parameter int OUT_DIM   = 32,
    parameter int ADDR_W    = 27,
    localparam int IW = $clog2(IN_DIM),
    localparam int OW = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [6:0]        token,
    input  logic              abort,
    input  logic              vec_wr_en,
    input  logic [IW-1:0]     vec_wr_idx,
    input  logic [DATA_W-1:0] vec_wr_data,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_ready,
    input  logic              rd_valid,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    output logic [OW-1:0]     out_idx,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
);
    localparam int ACC_W = 2 * DATA_W + IW;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_ACC  = 3'd3;
    localparam logic [2:0] S_EMIT = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    localparam logic [1:0] M_EMBED = 2'd0;
    localparam logic [1:0] M_RELU  = 2'd2;

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic [2:0]               state_q, state_d;
    logic [1:0]               mode_q, mode_d;
    logic [ADDR_W-1:0]        base_q, base_d;
    logic [6:0]               token_q, token_d;
    logic [IW-1:0]            i_q, i_d;
    logic [OW-1:0]            j_q, j_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [DATA_W-1:0] rdata_q, rdata_d;
    logic                     out_valid_q, out_valid_d;
    logic [OW-1:0]            out_idx_q, out_idx_d;
    logic [DATA_W-1:0]        out_data_q, out_data_d;
    logic signed [DATA_W-1:0] vec_q [IN_DIM];

    logic [IN_DIM-1:0]          vec_we;
    logic signed [2*DATA_W-1:0] product;
    logic signed [ACC_W-1:0]    acc_shift;
    logic signed [DATA_W-1:0]   emit_val;
    logic [ADDR_W-1:0]          row_off;
    logic                       is_embed, last_i, last_j;

    assign is_embed = (mode_q == M_EMBED);
    assign last_i   = (i_q == IW'(IN_DIM - 1));
    assign last_j   = (j_q == OW'(OUT_DIM - 1));

    assign busy      = (state_q != S_IDLE);
    assign rd_req    = (state_q == S_REQ);
    assign done      = (state_q == S_DONE);
    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_data  = out_data_q;

    // Address is derived from stable registers, so it cannot move while rd_req waits.
    assign row_off = is_embed ? ADDR_W'(token_q) * ADDR_W'(OUT_DIM) + ADDR_W'(j_q)
                              : ADDR_W'(j_q) * ADDR_W'(IN_DIM) + ADDR_W'(i_q);
    assign rd_addr = base_q + row_off;

    assign product   = (2*DATA_W)'(rdata_q) * (2*DATA_W)'(vec_q[i_q]);
    assign acc_shift = acc_q >>> FRAC_BITS;

    always_comb begin
        emit_val = acc_shift[DATA_W-1:0];
        if (acc_shift > SAT_MAX) begin
            emit_val = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (acc_shift < SAT_MIN) begin
            emit_val = {1'b1, {(DATA_W-1){1'b0}}};
        end
        if (mode_q == M_RELU && emit_val[DATA_W-1]) begin
            emit_val = '0;
        end
    end

    for (genvar gi = 0; gi < IN_DIM; gi++) begin : g_vec_we
        assign vec_we[gi] = vec_wr_en && !busy && (vec_wr_idx == IW'(gi));
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        base_d      = base_q;
        token_d     = token_q;
        i_d         = i_q;
        j_d         = j_q;
        acc_d       = acc_q;
        rdata_d     = rdata_q;
        out_valid_d = 1'b0;
        out_idx_d   = out_idx_q;
        out_data_d  = out_data_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    base_d  = base_addr;
                    token_d = token;
                    i_d     = '0;
                    j_d     = '0;
                    acc_d   = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (rd_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (rd_valid) begin
                    if (is_embed) begin
                        out_valid_d = 1'b1;
                        out_idx_d   = j_q;
                        out_data_d  = rd_data;
                        if (last_j) begin
                            state_d = S_DONE;
                        end else begin
                            j_d     = j_q + OW'(1);
                            state_d = S_REQ;
                        end
                    end else begin
                        rdata_d = rd_data;
                        state_d = S_ACC;
                    end
                end
            end
            S_ACC: begin
                acc_d = acc_q + ACC_W'(product);
                if (last_i) begin
                    state_d = S_EMIT;
                end else begin
                    i_d     = i_q + IW'(1);
                    state_d = S_REQ;
                end
            end
            S_EMIT: begin
                out_valid_d = 1'b1;
                out_idx_d   = j_q;
                out_data_d  = emit_val;
                acc_d       = '0;
                i_d         = '0;
                if (last_j) begin
                    state_d = S_DONE;
                end else begin
                    j_d     = j_q + OW'(1);
                    state_d = S_REQ;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Cancel wins over everything except a start issued from IDLE.
        if (abort && state_q != S_IDLE) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            mode_q      <= '0;
            base_q      <= '0;
            token_q     <= '0;
            i_q         <= '0;
            j_q         <= '0;
            acc_q       <= '0;
            rdata_q     <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            base_q      <= base_d;
            token_q     <= token_d;
            i_q         <= i_d;
            j_q         <= j_d;
            acc_q       <= acc_d;
            rdata_q     <= rdata_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_data_q  <= out_data_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < IN_DIM; k++) vec_q[k] <= '0;
        end else begin
            for (int k = 0; k < IN_DIM; k++) begin
                if (vec_we[k]) vec_q[k] <= vec_wr_data;
            end
        end
    end

endmodule

// File: doc/matvec_engine.md
MATVEC_ENGINE -- requirements
Module: matvec_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning signed fixed-point element width.
REQ-002 SHALL have parameter FRAC_BITS, default 8, meaning fractional bits of every element (Q8.8 at defaults).
REQ-003 SHALL have parameter IN_DIM, default 16, meaning input vector length (>=2).
REQ-004 SHALL have parameter OUT_DIM, default 32, meaning output vector length / embedding row length (>=1).
REQ-005 SHALL have parameter ADDR_W, default 27, meaning word address width of the weight store.
REQ-006 SHALL have port clk, input, 1, meaning the single clock; all logic on posedge clk.
REQ-007 SHALL have port reset_n, input, 1, meaning asynchronous active-low reset.
REQ-008 SHALL have port start, input, 1, meaning a one-cycle operation request, sampled in IDLE only.
REQ-009 SHALL have port mode, input, 2, meaning 0=EMBED, 1=MATVEC, 2=MATVEC_RELU, 3=reserved (treated as MATVEC), sampled with start.
REQ-010 SHALL have port base_addr, input, ADDR_W, meaning table/matrix base word address, sampled with start.
REQ-011 SHALL have port token, input, 7, meaning embedding row index (EMBED only), sampled with start.
REQ-012 SHALL have port abort, input, 1, meaning synchronous cancel of the current operation.
REQ-013 SHALL have ports vec_wr_en (input, 1), vec_wr_idx (input, clog2(IN_DIM)) and vec_wr_data (input, DATA_W), meaning the input-vector buffer write port.
REQ-014 SHALL have ports rd_req (output, 1), rd_addr (output, ADDR_W) and rd_ready (input, 1), meaning the read request handshake.
REQ-015 SHALL have ports rd_valid (input, 1) and rd_data (input, DATA_W), meaning the read response.
REQ-016 SHALL have ports out_valid (output, 1), out_idx (output, clog2(OUT_DIM)) and out_data (output, DATA_W), meaning the result element stream.
REQ-017 SHALL have ports busy (output, 1) and done (output, 1), meaning operation active and a one-cycle completion pulse.

Function
REQ-018 SHALL use FSM IDLE -> REQ -> WAIT -> (ACC | EMIT) -> ... -> DONE -> IDLE.
REQ-019 In IDLE, start SHALL latch mode/base_addr/token, clear row counter j and column counter i, zero the accumulator, enter REQ next cycle, and assert busy from that cycle.
REQ-020 In REQ, rd_req SHALL be held high with a stable rd_addr until rd_ready=1 (transfer), then enter WAIT; exactly one read outstanding.
REQ-021 rd_addr SHALL be base_addr + token*OUT_DIM + j in EMBED and base_addr + j*IN_DIM + i in MATVEC, computed modulo 2^ADDR_W.
REQ-022 rd_valid outside WAIT SHALL be ignored.
REQ-023 EMBED: on rd_valid in WAIT, out_data=rd_data, out_idx=j, out_valid=1 for one cycle, all on the next cycle.
REQ-024 MATVEC: on rd_valid in WAIT, acc += sign-extended full product rd_data*vec[i]; acc width 2*DATA_W+clog2(IN_DIM), no intermediate overflow.
REQ-025 MATVEC: after the product for i=IN_DIM-1, EMIT SHALL output (acc >>> FRAC_BITS), saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1], with out_idx=j and out_valid=1 for one cycle, then zero acc, i=0, j++.
REQ-026 MATVEC_RELU SHALL clamp negative EMIT results to 0 after saturation.
REQ-027 After element j=OUT_DIM-1 is emitted, the FSM SHALL enter DONE, pulse done for one cycle and return to IDLE with busy=0.
REQ-028 start while busy SHALL be ignored; vec_wr_en SHALL be ignored while busy, otherwise it writes vec[vec_wr_idx] in one cycle.
REQ-029 abort SHALL return the FSM to IDLE next cycle from any state: rd_req=0, no done, no further out_valid, and any late rd_valid ignored.
REQ-030 If abort and start are asserted together in IDLE, start SHALL win.

Reset
REQ-031 reset_n low SHALL asynchronously force IDLE with rd_req, out_valid, busy and done at 0, rd_addr, out_idx, out_data, acc and counters at 0.
REQ-032 The vector buffer SHALL be reset to all zeros; reset asserted mid-operation abandons the operation with no done.

Verification (IN_DIM=4, OUT_DIM=2, DATA_W=16, FRAC_BITS=8)
REQ-033 EMBED: base=0x100, token=3, memory returns 0x0011,0x0022 -> rd_addr 0x106,0x107; out (0,0x0011),(1,0x0022); done once.
REQ-034 MATVEC: vec={0x0100 x4}, W row0={0x0100,0x0200,0x0300,0x0400}, row1 all 0xFF00 -> out 0x0A00 then 0xFC00.
REQ-035 MATVEC_RELU with same data -> out 0x0A00 then 0x0000; saturation case: vec and W all 0x7FFF -> out 0x7FFF.
REQ-036 Back-pressure: rd_ready low for 5 cycles -> rd_req and rd_addr held stable, results unchanged.
REQ-037 abort asserted in WAIT, then late rd_valid -> no out_valid, no done, busy=0 the cycle after abort.
REQ-038 reset_n pulsed low mid-MATVEC -> all outputs 0 immediately; next start runs a full clean operation.
